// File: rtl/logisim_seq_pkg.sv
// Shared types and constants for the 4-bit pattern generator core.
// The prescaler feature is selected with LOGISIM_SEQ_PRESCALE_EN.
package logisim_seq_pkg;

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_GRAY = 2'b10,
    MODE_LFSR = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    LD_IDLE   = 2'b00,
    LD_SHIFT  = 2'b01,
    LD_COMMIT = 2'b10
  } ld_state_t;

  // x^4 + x^3 + 1: feedback is CNT[3] ^ CNT[2]
  localparam logic [3:0] LFSR_TAPS = 4'b1100;
  localparam logic [3:0] LFSR_SEED = 4'b0001;
  // State immediately preceding the seed in the LFSR sequence
  localparam logic [3:0] LFSR_LAST = 4'b1000;

endpackage

// File: rtl/logisim_seq_core_loader.sv
// Serial preset loader: shifts SDI in MSB first on SLD strobes, aborts after
// TIMEOUT idle cycles, and emits a one-cycle commit with the preset value.
module logisim_seq_loader
  import logisim_seq_pkg::*;
#(
  parameter int W       = 4,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sld,
  input  logic         sdi,
  output logic         busy,
  output logic         commit,
  output logic [W-1:0] preset,
  output ld_state_t    state
);

  localparam int BW = $clog2(W + 1);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT must be in 1..255");
  end

  ld_state_t      state_q, state_d;
  logic [W-1:0]   sr_q, sr_d, shift_in;
  logic [BW-1:0]  bits_q, bits_d;
  logic [7:0]     idle_q, idle_d;

  assign shift_in = (sr_q << 1) | W'(sdi);

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bits_d  = bits_q;
    idle_d  = idle_q;
    unique case (state_q)
      LD_IDLE: begin
        if (sld) begin
          sr_d    = shift_in;
          bits_d  = BW'(1);
          idle_d  = '0;
          state_d = (W == 1) ? LD_COMMIT : LD_SHIFT;
        end
      end
      LD_SHIFT: begin
        if (sld) begin
          sr_d   = shift_in;
          bits_d = bits_q + 1'b1;
          idle_d = '0;
          if (bits_q == BW'(W - 1)) state_d = LD_COMMIT;
        end else begin
          idle_d = idle_q + 1'b1;
          // Abort discards the partial preset so a stale value never commits
          if (idle_q == 8'(TIMEOUT - 1)) begin
            state_d = LD_IDLE;
            sr_d    = '0;
            bits_d  = '0;
            idle_d  = '0;
          end
        end
      end
      LD_COMMIT: begin
        state_d = LD_IDLE;
        bits_d  = '0;
        idle_d  = '0;
      end
      default: state_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LD_IDLE;
      sr_q    <= '0;
      bits_q  <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bits_q  <= bits_d;
      idle_q  <= idle_d;
    end
  end

  assign busy   = (state_q != LD_IDLE);
  assign commit = (state_q == LD_COMMIT);
  assign preset = sr_q;
  assign state  = state_q;

endmodule

// File: rtl/logisim_seq_core.sv
// 4-bit pattern generator (up, down, Gray, LFSR) with serial preset load.
// Define LOGISIM_SEQ_PRESCALE_EN to divide the advance rate by 2^PRESCALE_LOG2.
module logisim_seq_core
  import logisim_seq_pkg::*;
#(
  parameter int W             = 4,
  parameter int TIMEOUT       = 15,
  parameter int PRESCALE_LOG2 = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         EN,
  input  logic [1:0]   MODE,
  input  logic         SDI,
  input  logic         SLD,
  output logic [W-1:0] O,
  output logic         TC,
  output logic         BSY
);

  if (PRESCALE_LOG2 < 1) begin : g_bad_prescale
    $error("PRESCALE_LOG2 must be at least 1");
  end

  mode_t        mode;
  logic [W-1:0] cnt_q, cnt_next, preset;
  logic         commit, busy, enabled, advance, ps_full, at_end;
  ld_state_t    ld_state;

  assign mode = mode_t'(MODE);

  logisim_seq_loader #(.W(W), .TIMEOUT(TIMEOUT)) u_loader (
    .clk    (CLK),
    .rst_n  (RST),
    .sld    (SLD),
    .sdi    (SDI),
    .busy   (busy),
    .commit (commit),
    .preset (preset),
    .state  (ld_state)
  );

  assign BSY     = busy;
  assign enabled = EN & ~busy;

`ifdef LOGISIM_SEQ_PRESCALE_EN
  logic [PRESCALE_LOG2-1:0] ps_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)         ps_q <= '0;
    else if (commit)  ps_q <= '0;
    else if (enabled) ps_q <= ps_q + 1'b1;
  end

  // CNT steps on the enabled cycle in which the prescaler wraps back to zero
  assign ps_full = &ps_q;
`else
  assign ps_full = 1'b1;
`endif

  assign advance = enabled & ps_full;

  always_comb begin
    cnt_next = cnt_q;
    at_end   = 1'b0;
    unique case (mode)
      MODE_UP, MODE_GRAY: begin
        cnt_next = cnt_q + 1'b1;
        at_end   = &cnt_q;
      end
      MODE_DOWN: begin
        cnt_next = cnt_q - 1'b1;
        at_end   = (cnt_q == '0);
      end
      MODE_LFSR: begin
        // All-zero would lock the LFSR, so it re-seeds instead
        cnt_next = (cnt_q == '0) ? W'(LFSR_SEED)
                                 : {cnt_q[W-2:0], ^(cnt_q & W'(LFSR_TAPS))};
        at_end   = (cnt_q == W'(LFSR_LAST));
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)         cnt_q <= '0;
    else if (commit)  cnt_q <= preset;
    else if (advance) cnt_q <= cnt_next;
  end

  assign O  = (mode == MODE_GRAY) ? (cnt_q ^ (cnt_q >> 1)) : cnt_q;
  assign TC = RST & enabled & ps_full & at_end;

  a_commit_busy: assert property (@(posedge CLK) disable iff (!RST)
    (ld_state == LD_COMMIT) |-> (commit && BSY));

endmodule

// File: tb/tb_logisim_seq_core.sv
// Bench for logisim_seq_core: directed pattern/load/reset cases plus random
// stimulus compared every cycle against a behavioural model.
module tb_logisim_seq_core;

  localparam int W       = 4;
  localparam int TIMEOUT = 15;
  localparam int PS      = 16;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         en    = 1'b0;
  logic [1:0]   mode  = 2'b00;
  logic         sdi   = 1'b0;
  logic         sld   = 1'b0;
  logic [W-1:0] o;
  logic         tc, bsy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] e_o;

  int m_cnt, m_sr, m_nbits, m_gap, m_ps;
  bit m_commit, m_busy, m_adv;

  int gray_tab[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
  int lfsr_tab[15] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};

  logisim_seq_core #(.W(W), .TIMEOUT(TIMEOUT), .PRESCALE_LOG2(4)) dut (
    .CLK  (clk),
    .RST  (rst_n),
    .EN   (en),
    .MODE (mode),
    .SDI  (sdi),
    .SLD  (sld),
    .O    (o),
    .TC   (tc),
    .BSY  (bsy)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int step_val(input int c, input int md);
    case (md)
      0, 2:    return (c + 1) % 16;
      1:       return (c + 15) % 16;
      default: return (c == 0) ? 1 : ((c * 2) % 16) + (((c / 8) + (c / 4)) % 2);
    endcase
  endfunction

  function automatic int end_val(input int md);
    case (md)
      1:       return 0;
      3:       return 8;
      default: return 15;
    endcase
  endfunction

  function automatic logic [W-1:0] enc(input int c, input int md);
    return (md == 2) ? W'(c ^ (c / 2)) : W'(c);
  endfunction

  function automatic bit ps_full_m();
`ifdef LOGISIM_SEQ_PRESCALE_EN
    return (m_ps == PS - 1);
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_sr = 0; m_nbits = 0; m_gap = 0; m_ps = 0; m_commit = 0;
      exp_q.delete();
    end else begin
      m_busy = (m_nbits > 0) || m_commit;
      m_adv  = en && !m_busy;
      if (m_commit) begin
        m_cnt = m_sr; m_commit = 0; m_ps = 0;
      end else begin
        if (m_nbits > 0) begin
          if (sld) begin
            m_sr = (m_sr * 2 + int'(sdi)) % 16;
            m_nbits++; m_gap = 0;
            if (m_nbits == W) begin m_commit = 1; m_nbits = 0; end
          end else begin
            m_gap++;
            if (m_gap == TIMEOUT) begin m_nbits = 0; m_gap = 0; end
          end
        end else if (sld) begin
          m_sr = int'(sdi); m_nbits = 1; m_gap = 0;
        end
        if (m_adv) begin
`ifdef LOGISIM_SEQ_PRESCALE_EN
          m_ps = (m_ps + 1) % PS;
          if (m_ps == 0) m_cnt = step_val(m_cnt, int'(mode));
`else
          m_cnt = step_val(m_cnt, int'(mode));
`endif
        end
      end
      exp_q.push_back(enc(m_cnt, int'(mode)));
    end
  end

  // compare process
  always @(negedge clk) begin
    if (rst_n) begin
      m_busy = (m_nbits > 0) || m_commit;
      if (exp_q.size() == 0) begin
        check("o_queue_empty", 0, 1);
      end else begin
        e_o = exp_q.pop_front();
        check("o", o, e_o);
      end
      check("bsy", bsy, m_busy);
      check("tc", tc, en && !m_busy && ps_full_m() && (m_cnt == end_val(int'(mode))));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input logic t_en, input logic [1:0] t_mode, input logic t_sdi, input logic t_sld);
    @(negedge clk);
    #2;
    en = t_en; mode = t_mode; sdi = t_sdi; sld = t_sld;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0; en = 0; mode = 0; sdi = 0; sld = 0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic async_reset_check(input string tag);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check({tag, "_o"}, o, 0);
    check({tag, "_bsy"}, bsy, 0);
    check({tag, "_tc"}, tc, 0);
    @(negedge clk);
    #2;
    en = 0; mode = 0; sdi = 0; sld = 0;
    rst_n = 1'b1;
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check("rst_o", o, 0);
    check("rst_tc", tc, 0);
    check("rst_bsy", bsy, 0);
    #2 rst_n = 1'b1;

`ifndef LOGISIM_SEQ_PRESCALE_EN
    // up count, 17 cycles
    for (int k = 1; k <= 17; k++) begin
      tick(1, 2'b00, 0, 0);
      if (k == 15) check("up_tc_early", tc, 0);
      if (k == 16) begin check("up_o15", o, 15); check("up_tc15", tc, 1); end
      if (k == 17) check("up_wrap", o, 0);
    end

    // down count then drop EN
    tick(1, 2'b01, 0, 0); check("dn_o1", o, 1); check("dn_tc1", tc, 0);
    tick(1, 2'b01, 0, 0); check("dn_o0", o, 0); check("dn_tc0", tc, 1);
    tick(1, 2'b01, 0, 0); check("dn_o15", o, 15);
    tick(0, 2'b01, 0, 0); check("dn_o14", o, 14); check("dn_tc_off", tc, 0);
    tick(0, 2'b01, 0, 0); check("dn_hold", o, 14);

    // Gray
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      tick(1, 2'b10, 0, 0);
      if (k <= 16) check("gray_seq", o, gray_tab[k-1]);
      if (k >= 2 && k <= 16) check("gray_onebit", $countones(o ^ W'(gray_tab[k-2])), 1);
      if (k == 16) check("gray_tc", tc, 1);
      if (k == 17) check("gray_wrap", o, 0);
    end

    // LFSR
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      tick(1, 2'b11, 0, 0);
      if (k == 1) check("lfsr_start", o, 0);
      else begin
        check("lfsr_seq", o, lfsr_tab[(k-2) % 15]);
        check("lfsr_nonzero", o != 0, 1);
      end
      if (k == 16) check("lfsr_tc", tc, 1);
    end

    // serial load 1,0,1,1 with EN held
    do_reset();
    repeat (3) tick(1, 2'b00, 0, 0);
    tick(1, 2'b00, 1, 1); check("ld_pre_bsy", bsy, 0); check("ld_pre_o", o, 3);
    tick(1, 2'b00, 0, 0); check("ld_bsy_first", bsy, 1); check("ld_frozen_a", o, 4);
    repeat (2) tick(1, 2'b00, 0, 0);
    tick(1, 2'b00, 0, 1);
    tick(1, 2'b00, 0, 0);
    tick(1, 2'b00, 1, 1);
    tick(1, 2'b00, 1, 1); check("ld_frozen_b", o, 4);
    tick(1, 2'b00, 0, 0); check("ld_commit_bsy", bsy, 1);
    tick(1, 2'b00, 0, 0); check("ld_value", o, 11); check("ld_done_bsy", bsy, 0);
    tick(1, 2'b00, 0, 0); check("ld_resume", o, 12);

    // abort after 15 idle cycles
    do_reset();
    tick(0, 2'b00, 1, 1);
    tick(0, 2'b00, 1, 1);
    for (int i = 1; i <= 16; i++) begin
      tick(0, 2'b00, 0, 0);
      if (i == 15) check("ab_still_bsy", bsy, 1);
      if (i == 16) begin check("ab_bsy", bsy, 0); check("ab_cnt", o, 0); end
    end
    tick(1, 2'b00, 0, 0);
    tick(1, 2'b00, 0, 0); check("ab_counts", o, 1);

    // async reset mid-shift
    repeat (3) tick(1, 2'b00, 0, 0);
    tick(1, 2'b00, 1, 1);
    tick(1, 2'b00, 0, 1);
    async_reset_check("arst");
`endif

    // random stimulus
    begin
      logic [1:0] r_mode;
      r_mode = 2'b00;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(0, 7) == 0) r_mode = 2'($urandom_range(0, 3));
        if (n % 400 == 399) begin
          repeat (20) tick(1'($urandom_range(0, 1)), r_mode, 0, 0);
        end else if (n % 997 == 996) begin
          async_reset_check("rnd_arst");
        end else begin
          tick($urandom_range(0, 3) != 0, r_mode, 1'($urandom_range(0, 1)),
               $urandom_range(0, 3) == 0);
        end
      end
    end

    tick(0, 2'b00, 0, 0);
    @(negedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
